// File: rtl/mono_tx_pkg.sv
// Shared widths, word layout and FSM encoding for the MONOPIX serial hit transmitter.
package mono_tx_pkg;

    localparam int unsigned COL_W     = 6;
    localparam int unsigned ROW_W     = 8;
    localparam int unsigned TS_W      = 6;
    localparam int unsigned WORD_BITS = 26;

    // Word layout: col[25:20] row[19:12] te[11:6] le[5:0]
    localparam int unsigned LE_LSB  = 0;
    localparam int unsigned TE_LSB  = LE_LSB + TS_W;
    localparam int unsigned ROW_LSB = TE_LSB + TS_W;
    localparam int unsigned COL_LSB = ROW_LSB + ROW_W;

    // Bit counter width, enough to hold WORD_BITS-1
    localparam int unsigned BITCNT_W = $clog2(WORD_BITS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    // Binary to gray for timestamp fields
    function automatic logic [TS_W-1:0] gray_enc(input logic [TS_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Assemble one serial word from its fields
    function automatic logic [WORD_BITS-1:0] pack_word(
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] row,
        input logic [TS_W-1:0]  te,
        input logic [TS_W-1:0]  le
    );
        return (WORD_BITS'(col) << COL_LSB) |
               (WORD_BITS'(row) << ROW_LSB) |
               (WORD_BITS'(te)  << TE_LSB)  |
               (WORD_BITS'(le)  << LE_LSB);
    endfunction

endpackage

// File: rtl/generic_fifo.sv
// Generic synchronous FIFO with first-word fall-through read data and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module generic_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 26
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_wr_c, do_rd_c;

    // Guard against overflow/underflow regardless of caller behaviour
    always_comb begin
        do_wr_c = wr_en & ~full;
        do_rd_c = rd_en & ~empty;
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_wr_c) - (AW+1)'(do_rd_c);
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;

endmodule

// File: rtl/mono_data_tx.sv
// MONOPIX serial hit transmitter emulator: buffers hits, raises TOKEN, shifts one
// 26-bit word MSB first per READ.
// Optional build macro MONO_TX_GRAY_EN: gray-encode le/te before storing.
module mono_data_tx
    import mono_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic              HIT_WR,
    input  logic [COL_W-1:0]  HIT_COL,
    input  logic [ROW_W-1:0]  HIT_ROW,
    input  logic [TS_W-1:0]   HIT_LE,
    input  logic [TS_W-1:0]   HIT_TE,
    input  logic              FREEZE,
    input  logic              READ,
    output logic              TOKEN,
    output logic              DATA,
    output logic              BUSY,
    output logic              READ_ERR,
    output logic [7:0]        LOST_CNT
);

    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned CNT_W      = FIFO_DEPTH_LOG2 + 1;

    tx_state_e              state_q;
    logic [WORD_BITS-1:0]   shreg_q;
    logic [BITCNT_W-1:0]    bitcnt_q;
    logic                   data_q, busy_q, token_q, read_err_q;
    logic [7:0]             lost_q;

    logic [WORD_BITS-1:0]   hit_word_c, fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count, count_d;
    logic                   push_c, drop_c, pop_c;
    logic                   token_d, read_err_d;
    logic [7:0]             lost_d;

    // Word formation at push time
    always_comb begin
`ifdef MONO_TX_GRAY_EN
        hit_word_c = pack_word(HIT_COL, HIT_ROW, gray_enc(HIT_TE), gray_enc(HIT_LE));
`else
        hit_word_c = pack_word(HIT_COL, HIT_ROW, HIT_TE, HIT_LE);
`endif
    end

    // Push/drop/pop decisions and next values for status registers
    always_comb begin
        push_c     = HIT_WR & ~FREEZE & ~fifo_full;
        drop_c     = HIT_WR & (FREEZE | fifo_full);
        pop_c      = READ & (state_q == ST_IDLE) & ~fifo_empty;
        count_d    = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
        token_d    = (count_d != '0);
        lost_d     = lost_q;
        if (drop_c && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end
        read_err_d = read_err_q | (READ & ((state_q == ST_SHIFT) | fifo_empty));
    end

    generic_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_BITS)
    ) u_fifo (
        .clk     (BUS_CLK),
        .rst     (BUS_RST),
        .wr_en   (push_c),
        .wr_data (hit_word_c),
        .rd_en   (pop_c),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Transmit FSM, shifter and registered status outputs
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            data_q     <= 1'b0;
            busy_q     <= 1'b0;
            token_q    <= 1'b0;
            read_err_q <= 1'b0;
            lost_q     <= '0;
        end else begin
            token_q    <= token_d;
            read_err_q <= read_err_d;
            lost_q     <= lost_d;
            case (state_q)
                ST_IDLE: begin
                    if (pop_c) begin
                        // MSB goes out next cycle; the rest waits left-aligned
                        data_q   <= fifo_rdata[WORD_BITS-1];
                        shreg_q  <= {fifo_rdata[WORD_BITS-2:0], 1'b0};
                        bitcnt_q <= BITCNT_W'(WORD_BITS - 1);
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bitcnt_q == '0) begin
                        data_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        data_q   <= shreg_q[WORD_BITS-1];
                        shreg_q  <= {shreg_q[WORD_BITS-2:0], 1'b0};
                        bitcnt_q <= bitcnt_q - BITCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign TOKEN    = token_q;
    assign DATA     = data_q;
    assign BUSY     = busy_q;
    assign READ_ERR = read_err_q;
    assign LOST_CNT = lost_q;

endmodule

// File: tb/tb_mono_data_tx.sv
// Self-checking bench for mono_data_tx with a queue-based reference model.
module tb_mono_data_tx;

    logic       BUS_CLK = 1'b0;
    logic       BUS_RST = 1'b0;
    logic       HIT_WR  = 1'b0;
    logic [5:0] HIT_COL = '0;
    logic [7:0] HIT_ROW = '0;
    logic [5:0] HIT_LE  = '0;
    logic [5:0] HIT_TE  = '0;
    logic       FREEZE  = 1'b0;
    logic       READ    = 1'b0;
    logic       TOKEN, DATA, BUSY, READ_ERR;
    logic [7:0] LOST_CNT;

    int checks   = 0;
    int failures = 0;

    logic [25:0] model_q[$];
    int          lost_m = 0;
    bit          err_m  = 1'b0;

    mono_data_tx dut (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .HIT_WR   (HIT_WR),
        .HIT_COL  (HIT_COL),
        .HIT_ROW  (HIT_ROW),
        .HIT_LE   (HIT_LE),
        .HIT_TE   (HIT_TE),
        .FREEZE   (FREEZE),
        .READ     (READ),
        .TOKEN    (TOKEN),
        .DATA     (DATA),
        .BUSY     (BUSY),
        .READ_ERR (READ_ERR),
        .LOST_CNT (LOST_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    function automatic logic [25:0] exp_word(input int col, input int row, input int te, input int le);
        int t, l;
        t = te;
        l = le;
`ifdef MONO_TX_GRAY_EN
        t = te ^ (te / 2);
        l = le ^ (le / 2);
`endif
        return 26'(col * 1048576 + row * 4096 + t * 64 + l);
    endfunction

    task automatic tick;
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic do_reset;
        BUS_RST = 1'b1;
        tick;
        tick;
        BUS_RST = 1'b0;
        model_q.delete();
        lost_m = 0;
        err_m  = 1'b0;
    endtask

    task automatic push_hit(input int col, input int row, input int te, input int le, input bit frz);
        FREEZE  = frz;
        HIT_WR  = 1'b1;
        HIT_COL = 6'(col);
        HIT_ROW = 8'(row);
        HIT_TE  = 6'(te);
        HIT_LE  = 6'(le);
        tick;
        HIT_WR  = 1'b0;
        FREEZE  = 1'b0;
        if (frz || model_q.size() >= 16) begin
            if (lost_m < 255) lost_m++;
        end else begin
            model_q.push_back(exp_word(col, row, te, le));
        end
        checks++;
        if (TOKEN !== (model_q.size() != 0)) begin
            failures++;
            $display("FAIL token_after_push got=%b exp=%b", TOKEN, model_q.size() != 0);
        end
        checks++;
        if (LOST_CNT !== 8'(lost_m)) begin
            failures++;
            $display("FAIL lost_cnt got=%0d exp=%0d", LOST_CNT, lost_m);
        end
    endtask

    task automatic push_rand(input bit frz);
        push_hit($urandom_range(0, 63), $urandom_range(0, 255), $urandom_range(0, 63), $urandom_range(0, 63), frz);
    endtask

    // Issue READ, collect 26 serial bits and compare against the model's oldest word
    task automatic read_word(input string name, input int err_at, output logic [25:0] got);
        logic [25:0] exp;
        bit busy_bad;
        busy_bad = 1'b0;
        got      = '0;
        exp      = model_q.pop_front();
        READ = 1'b1;
        tick;
        READ = 1'b0;
        checks++;
        if (TOKEN !== (model_q.size() != 0)) begin
            failures++;
            $display("FAIL %s_token got=%b exp=%b", name, TOKEN, model_q.size() != 0);
        end
        for (int k = 0; k < 26; k++) begin
            got = {got[24:0], DATA};
            if (BUSY !== 1'b1) busy_bad = 1'b1;
            if (k == err_at) begin
                READ  = 1'b1;
                err_m = 1'b1;
            end
            tick;
            READ = 1'b0;
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s_word got=%h exp=%h", name, got, exp);
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL %s_busy got=0 exp=1 during shift", name);
        end
        checks++;
        if (DATA !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s_end got data=%b busy=%b exp 0/0", name, DATA, BUSY);
        end
        checks++;
        if (READ_ERR !== err_m) begin
            failures++;
            $display("FAIL %s_read_err got=%b exp=%b", name, READ_ERR, err_m);
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({TOKEN, DATA, BUSY, READ_ERR} !== 4'b0000 || LOST_CNT !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got tok=%b data=%b busy=%b err=%b lost=%0d exp all 0",
                     TOKEN, DATA, BUSY, READ_ERR, LOST_CNT);
        end
    endtask

    task automatic test_single_word;
        logic [25:0] got, vec;
`ifdef MONO_TX_GRAY_EN
        vec = 26'h52A342;
`else
        vec = 26'h52A243;
`endif
        push_hit(5, 8'h2A, 9, 3, 1'b0);
        FREEZE = 1'b1;
        read_word("single", -1, got);
        FREEZE = 1'b0;
        checks++;
        if (got !== vec) begin
            failures++;
            $display("FAIL single_vector got=%h exp=%h", got, vec);
        end
    endtask

    task automatic test_overflow;
        logic [25:0] got;
        do_reset;
        for (int i = 0; i < 17; i++) push_rand(1'b0);
        checks++;
        if (LOST_CNT !== 8'd1) begin
            failures++;
            $display("FAIL overflow_lost got=%0d exp=1", LOST_CNT);
        end
        for (int i = 0; i < 16; i++) read_word("overflow", -1, got);
        checks++;
        if (TOKEN !== 1'b0) begin
            failures++;
            $display("FAIL overflow_token_end got=%b exp=0", TOKEN);
        end
    endtask

    task automatic test_random;
        logic [25:0] got;
        do_reset;
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) push_rand($urandom_range(0, 3) == 0);
            while (model_q.size() != 0) read_word("random", -1, got);
        end
    endtask

    task automatic test_freeze;
        logic [25:0] got;
        do_reset;
        push_rand(1'b0);
        for (int i = 0; i < 300; i++) push_rand(1'b1);
        checks++;
        if (LOST_CNT !== 8'd255 || TOKEN !== 1'b1) begin
            failures++;
            $display("FAIL freeze_sat got lost=%0d tok=%b exp 255/1", LOST_CNT, TOKEN);
        end
        read_word("freeze", -1, got);
    endtask

    task automatic test_read_err;
        logic [25:0] got;
        bit bad;
        do_reset;
        bad  = 1'b0;
        READ = 1'b1;
        tick;
        READ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (DATA !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
            tick;
        end
        checks++;
        if (READ_ERR !== 1'b1 || bad) begin
            failures++;
            $display("FAIL empty_read got err=%b idle_bad=%b exp 1/0", READ_ERR, bad);
        end
        do_reset;
        push_rand(1'b0);
        push_rand(1'b0);
        read_word("read_in_shift", 9, got);
        read_word("after_err", -1, got);
    endtask

    task automatic test_mid_reset;
        logic [25:0] got, exp;
        do_reset;
        push_rand(1'b0);
        push_rand(1'b0);
        exp  = model_q[0];
        READ = 1'b1;
        tick;
        READ = 1'b0;
        for (int i = 0; i < 13; i++) tick;
        checks++;
        if (DATA !== exp[12]) begin
            failures++;
            $display("FAIL mid_bit12 got=%b exp=%b", DATA, exp[12]);
        end
        BUS_RST = 1'b1;
        tick;
        BUS_RST = 1'b0;
        model_q.delete();
        lost_m = 0;
        err_m  = 1'b0;
        checks++;
        if (DATA !== 1'b0 || BUSY !== 1'b0 || TOKEN !== 1'b0 || READ_ERR !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got data=%b busy=%b tok=%b err=%b exp 0",
                     DATA, BUSY, TOKEN, READ_ERR);
        end
        push_rand(1'b0);
        read_word("post_reset", -1, got);
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_overflow;
        test_random;
        test_freeze;
        test_read_err;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
